// File: rtl/eeg_dat_rx.sv
// rtl/eeg_dat_rx.sv - packs CHIP_DAT_DW pad beats into OUT_DW words with lane enables
//
// Optional feature: define EEG_RX_STAT_EN to build the accepted-frame counter.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   chip_dat_vld     pad beat valid
//   chip_dat_lst     last beat of a frame
//   chip_dat_cmd     beat belongs to a command (1) or data (0) frame
//   chip_dat_dat     pad beat payload
//   chip_dat_rdy     block accepts a beat this cycle
//   out_vld/out_rdy  packed word handshake
//   out_dat          packed word, first beat in lane 0
//   out_ben          lane enables
//   out_lst          word closes a frame
//   out_cmd          word type
//   rx_err           sticky protocol-error flag
//   rx_frm_cnt       frames leaving with out_lst=1 (0 unless EEG_RX_STAT_EN)
module eeg_dat_rx #(
    parameter int CHIP_DAT_DW = 8,
    parameter int OUT_DW      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          chip_dat_vld,
    input  logic                          chip_dat_lst,
    input  logic                          chip_dat_cmd,
    input  logic [CHIP_DAT_DW-1:0]        chip_dat_dat,
    output logic                          chip_dat_rdy,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [OUT_DW-1:0]             out_dat,
    output logic [OUT_DW/CHIP_DAT_DW-1:0] out_ben,
    output logic                          out_lst,
    output logic                          out_cmd,
    output logic                          rx_err,
    output logic [15:0]                   rx_frm_cnt
);

    localparam int RATIO = OUT_DW / CHIP_DAT_DW;
    localparam int LCW   = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [LCW-1:0]    lane_cnt;
    logic              type_r;
    logic [OUT_DW-1:0] word_r;
    logic [RATIO-1:0]  ben_r;

    logic              beat_acc;
    logic              proto_err;
    logic              beat_ok;
    logic              last_lane;
    logic              load;
    logic [OUT_DW-1:0] asm_word;
    logic [RATIO-1:0]  asm_ben;
    logic              asm_cmd;

    // Single output register: a new word may load whenever the current one
    // is absent or leaving this cycle.
    assign chip_dat_rdy = !out_vld || out_rdy;
    assign beat_acc     = chip_dat_vld && chip_dat_rdy;

    // A type change in the middle of a word is a framing error; the beat is dropped.
    assign proto_err = beat_acc && (lane_cnt != '0) && (chip_dat_cmd != type_r);
    assign beat_ok   = beat_acc && !proto_err;
    assign last_lane = (lane_cnt == LCW'(RATIO - 1));
    assign load      = beat_ok && (last_lane || chip_dat_lst);

    // Partial word is kept zeroed between words, so writing the current lane
    // into it yields both the stored partial and the word to emit.
    always_comb begin
        asm_word = word_r;
        asm_ben  = ben_r;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_cnt == LCW'(i)) begin
                asm_word[i*CHIP_DAT_DW +: CHIP_DAT_DW] = chip_dat_dat;
                asm_ben[i] = 1'b1;
            end
        end
        asm_cmd = (lane_cnt == '0) ? chip_dat_cmd : type_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            type_r   <= 1'b0;
            word_r   <= '0;
            ben_r    <= '0;
            rx_err   <= 1'b0;
        end else begin
            if (proto_err) begin
                rx_err <= 1'b1;
            end
            if (proto_err || load) begin
                lane_cnt <= '0;
                word_r   <= '0;
                ben_r    <= '0;
            end else if (beat_ok) begin
                lane_cnt <= lane_cnt + 1'b1;
                word_r   <= asm_word;
                ben_r    <= asm_ben;
                if (lane_cnt == '0) begin
                    type_r <= chip_dat_cmd;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_ben <= '0;
            out_lst <= 1'b0;
            out_cmd <= 1'b0;
        end else if (load) begin
            out_vld <= 1'b1;
            out_dat <= asm_word;
            out_ben <= asm_ben;
            out_lst <= chip_dat_lst;
            out_cmd <= asm_cmd;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

`ifdef EEG_RX_STAT_EN
    logic [15:0] frm_cnt_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_cnt_r <= 16'd0;
        end else if (out_vld && out_rdy && out_lst) begin
            frm_cnt_r <= frm_cnt_r + 16'd1;
        end
    end

    assign rx_frm_cnt = frm_cnt_r;
`else
    assign rx_frm_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_eeg_dat_rx.sv
// tb/tb_eeg_dat_rx.sv - directed self-checking bench for eeg_dat_rx
module tb_eeg_dat_rx;

`ifdef EEG_RX_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chip_dat_vld = 1'b0;
    logic        chip_dat_lst = 1'b0;
    logic        chip_dat_cmd = 1'b0;
    logic [7:0]  chip_dat_dat = 8'h00;
    logic        chip_dat_rdy;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [31:0] out_dat;
    logic [3:0]  out_ben;
    logic        out_lst;
    logic        out_cmd;
    logic        rx_err;
    logic [15:0] rx_frm_cnt;

    int checks = 0;
    int errors = 0;

    eeg_dat_rx #(.CHIP_DAT_DW(8), .OUT_DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .chip_dat_vld (chip_dat_vld),
        .chip_dat_lst (chip_dat_lst),
        .chip_dat_cmd (chip_dat_cmd),
        .chip_dat_dat (chip_dat_dat),
        .chip_dat_rdy (chip_dat_rdy),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_dat      (out_dat),
        .out_ben      (out_ben),
        .out_lst      (out_lst),
        .out_cmd      (out_cmd),
        .rx_err       (rx_err),
        .rx_frm_cnt   (rx_frm_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic c, input logic l);
        chip_dat_vld = 1'b1;
        chip_dat_dat = d;
        chip_dat_cmd = c;
        chip_dat_lst = l;
        step();
        chip_dat_vld = 1'b0;
        chip_dat_lst = 1'b0;
    endtask

    task automatic idle();
        chip_dat_vld = 1'b0;
        chip_dat_lst = 1'b0;
        step();
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_out_dat", out_dat, 32'd0);
        chk("rst_out_ben", {28'd0, out_ben}, 32'd0);
        chk("rst_out_lst", {31'd0, out_lst}, 32'd0);
        chk("rst_out_cmd", {31'd0, out_cmd}, 32'd0);
        chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
        chk("rst_frm_cnt", {16'd0, rx_frm_cnt}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_rdy", {31'd0, chip_dat_rdy}, 32'd1);

        // 8-beat data frame
        out_rdy = 1'b1;
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0);
        chk("d8_no_early", {31'd0, out_vld}, 32'd0);
        beat(8'h04, 1'b0, 1'b0);
        chk("d8_w0_vld", {31'd0, out_vld}, 32'd1);
        chk("d8_w0_dat", out_dat, 32'h04030201);
        chk("d8_w0_ben", {28'd0, out_ben}, 32'hF);
        chk("d8_w0_lst", {31'd0, out_lst}, 32'd0);
        beat(8'h05, 1'b0, 1'b0);
        chk("d8_gap_vld", {31'd0, out_vld}, 32'd0);
        beat(8'h06, 1'b0, 1'b0);
        beat(8'h07, 1'b0, 1'b0);
        beat(8'h08, 1'b0, 1'b1);
        chk("d8_w1_vld", {31'd0, out_vld}, 32'd1);
        chk("d8_w1_dat", out_dat, 32'h08070605);
        chk("d8_w1_ben", {28'd0, out_ben}, 32'hF);
        chk("d8_w1_lst", {31'd0, out_lst}, 32'd1);
        chk("d8_w1_cmd", {31'd0, out_cmd}, 32'd0);
        idle();
        chk("d8_no_extra", {31'd0, out_vld}, 32'd0);
        chk("d8_frm_cnt", {16'd0, rx_frm_cnt}, STAT ? 32'd1 : 32'd0);

        // 3-beat command frame
        beat(8'hA1, 1'b1, 1'b0);
        beat(8'hA2, 1'b1, 1'b0);
        beat(8'hA3, 1'b1, 1'b1);
        chk("c3_vld", {31'd0, out_vld}, 32'd1);
        chk("c3_dat", out_dat, 32'h00A3A2A1);
        chk("c3_ben", {28'd0, out_ben}, 32'h7);
        chk("c3_lst", {31'd0, out_lst}, 32'd1);
        chk("c3_cmd", {31'd0, out_cmd}, 32'd1);
        idle();
        chk("c3_frm_cnt", {16'd0, rx_frm_cnt}, STAT ? 32'd2 : 32'd0);

        // single-beat frames back to back: second replaces first in one cycle
        beat(8'h7E, 1'b0, 1'b1);
        chk("s1_dat", out_dat, 32'h0000007E);
        chk("s1_ben", {28'd0, out_ben}, 32'h1);
        beat(8'h62, 1'b1, 1'b1);
        chk("s2_vld", {31'd0, out_vld}, 32'd1);
        chk("s2_dat", out_dat, 32'h00000062);
        chk("s2_cmd", {31'd0, out_cmd}, 32'd1);
        idle();

        // backpressure: out_rdy low for 10 cycles with input waiting
        out_rdy = 1'b0;
        beat(8'h10, 1'b0, 1'b0);
        beat(8'h11, 1'b0, 1'b0);
        beat(8'h12, 1'b0, 1'b0);
        chk("bp_rdy_before", {31'd0, chip_dat_rdy}, 32'd1);
        beat(8'h13, 1'b0, 1'b0);
        chk("bp_w0_dat", out_dat, 32'h13121110);
        chk("bp_rdy_drop", {31'd0, chip_dat_rdy}, 32'd0);
        chip_dat_vld = 1'b1;
        chip_dat_dat = 8'h14;
        chip_dat_cmd = 1'b0;
        chip_dat_lst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_vld", {31'd0, out_vld}, 32'd1);
            chk("bp_hold_dat", out_dat, 32'h13121110);
            chk("bp_hold_rdy", {31'd0, chip_dat_rdy}, 32'd0);
        end
        out_rdy = 1'b1;
        step();
        chip_dat_vld = 1'b0;
        chk("bp_release_vld", {31'd0, out_vld}, 32'd0);
        beat(8'h15, 1'b0, 1'b0);
        beat(8'h16, 1'b0, 1'b0);
        beat(8'h17, 1'b0, 1'b1);
        chk("bp_w1_dat", out_dat, 32'h17161514);
        chk("bp_w1_ben", {28'd0, out_ben}, 32'hF);
        chk("bp_w1_lst", {31'd0, out_lst}, 32'd1);
        idle();

        // command type change mid-word
        beat(8'h20, 1'b0, 1'b0);
        beat(8'h21, 1'b1, 1'b0);
        chk("err_flag", {31'd0, rx_err}, 32'd1);
        chk("err_no_word", {31'd0, out_vld}, 32'd0);
        beat(8'h30, 1'b0, 1'b0);
        beat(8'h31, 1'b0, 1'b0);
        beat(8'h32, 1'b0, 1'b0);
        chk("err_no_early", {31'd0, out_vld}, 32'd0);
        beat(8'h33, 1'b0, 1'b0);
        chk("err_next_vld", {31'd0, out_vld}, 32'd1);
        chk("err_next_dat", out_dat, 32'h33323130);
        chk("err_next_ben", {28'd0, out_ben}, 32'hF);
        chk("err_next_cmd", {31'd0, out_cmd}, 32'd0);
        chk("err_sticky", {31'd0, rx_err}, 32'd1);
        idle();

        // reset mid-word
        beat(8'h40, 1'b0, 1'b0);
        beat(8'h41, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_vld", {31'd0, out_vld}, 32'd0);
        chk("mr_err_clr", {31'd0, rx_err}, 32'd0);
        chk("mr_frm_clr", {16'd0, rx_frm_cnt}, 32'd0);
        chk("mr_rdy", {31'd0, chip_dat_rdy}, 32'd1);
        beat(8'h50, 1'b0, 1'b0);
        beat(8'h51, 1'b0, 1'b0);
        beat(8'h52, 1'b0, 1'b0);
        chk("mr_no_early", {31'd0, out_vld}, 32'd0);
        beat(8'h53, 1'b0, 1'b0);
        chk("mr_dat", out_dat, 32'h53525150);
        chk("mr_ben", {28'd0, out_ben}, 32'hF);
        idle();
        chk("mr_single", {31'd0, out_vld}, 32'd0);

        // frame counter wrap: 65537 single-beat frames after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 65537; i++) begin
            beat(8'(i), 1'b0, 1'b1);
        end
        chk("wrap_last_dat", out_dat, 32'h00000001);
        idle();
        chk("wrap_frm_cnt", {16'd0, rx_frm_cnt}, STAT ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeg_dat_rx.md
EEG_DAT_RX -- requirements
Module: eeg_dat_rx

Interface
REQ-001 Parameter CHIP_DAT_DW, default 8: pad-side beat width in bits.
REQ-002 Parameter OUT_DW, default 32: internal word width; SHALL be an integer multiple of CHIP_DAT_DW; RATIO = OUT_DW/CHIP_DAT_DW, default 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 chip_dat_vld  input  1  pad beat valid.
REQ-006 chip_dat_lst  input  1  last beat of a frame.
REQ-007 chip_dat_cmd  input  1  beat belongs to a command frame (1) or a data frame (0).
REQ-008 chip_dat_dat  input  CHIP_DAT_DW  pad beat payload.
REQ-009 chip_dat_rdy  output  1  block can accept a beat this cycle.
REQ-010 out_vld  output  1  packed word valid.
REQ-011 out_rdy  input  1  downstream accepts the word.
REQ-012 out_dat  output  OUT_DW  packed word; first beat in the least-significant lane.
REQ-013 out_ben  output  RATIO  lane enables, one per CHIP_DAT_DW lane.
REQ-014 out_lst  output  1  word closes a frame.
REQ-015 out_cmd  output  1  word is command (1) or data (0).
REQ-016 rx_err  output  1  sticky protocol-error flag.
REQ-017 rx_frm_cnt  output  16  accepted-frame counter (see Configuration).

Function
REQ-018 A beat transfers when chip_dat_vld && chip_dat_rdy; an output word transfers when out_vld && out_rdy.
REQ-019 chip_dat_rdy SHALL equal !out_vld || out_rdy (one output register, combinational backpressure, no bubble under continuous flow).
REQ-020 Lane counter lane_cnt (0..RATIO-1) selects the lane written by each accepted beat; it increments per beat and wraps to 0 after lane RATIO-1 or after a lst beat.
REQ-021 Word cmd type SHALL be taken from chip_dat_cmd of the lane-0 beat and held in a type register until the word is emitted.
REQ-022 When the beat filling lane RATIO-1 is accepted, or any beat with chip_dat_lst=1 is accepted, the assembled word SHALL be loaded into the output register on that edge: out_vld=1 in the next cycle (latency 1 from the completing beat).
REQ-023 Unwritten lanes of a lst-truncated word SHALL be zero; out_ben bit i = 1 exactly for written lanes; full words have out_ben all ones.
REQ-024 out_lst = chip_dat_lst of the completing beat; out_cmd = type register.
REQ-025 Output register contents SHALL be stable while out_vld && !out_rdy.
REQ-026 Protocol error: an accepted beat at lane_cnt != 0 whose chip_dat_cmd differs from the type register SHALL discard the partial word, set rx_err, reset lane_cnt to 0, and the offending beat SHALL be dropped (next accepted beat starts a new word at lane 0).
REQ-027 rx_err SHALL stay 1 until reset.
REQ-028 Simultaneous output-transfer and new-word-load in one cycle SHALL replace the output register (out_vld stays 1).
REQ-029 A lst beat landing in lane RATIO-1 yields one full word with out_lst=1; no extra empty word.

Reset
REQ-030 While rst_n=0 at a clock edge: out_vld=0, out_dat=0, out_ben=0, out_lst=0, out_cmd=0, rx_err=0, rx_frm_cnt=0, lane_cnt=0, partial word cleared; chip_dat_rdy=1 in the first cycle after reset.
REQ-031 Reset asserted mid-frame SHALL discard any partial or pending word; no word is emitted for it after release.

Configuration
REQ-032 Macro EEG_RX_STAT_EN: when defined, rx_frm_cnt increments by 1 (mod 2^16, wraps 0xFFFF->0x0000) on each output transfer with out_lst=1, data and command frames alike.
REQ-033 Without EEG_RX_STAT_EN, rx_frm_cnt SHALL be constant 0 and the counter logic SHALL not be present.

Verification
REQ-034 Data frame of 8 beats 0x01..0x08 (lst on 8th), out_rdy=1 -> two words 0x04030201 (ben 0xF, lst 0) and 0x08070605 (ben 0xF, lst 1, cmd 0), each one cycle after its 4th beat.
REQ-035 Command frame of 3 beats 0xA1,0xA2,0xA3 with cmd=1 -> one word 0x00A3A2A1, ben 0x7, lst 1, cmd 1.
REQ-036 out_rdy held 0 for 10 cycles with continuous input -> chip_dat_rdy drops after the first word loads, out_dat unchanged for all 10 cycles, no beat lost or duplicated after release.
REQ-037 cmd toggles 0->1 on 2nd beat of a word -> rx_err=1 next cycle, no word emitted for that partial, following 4 cmd=0 beats form a normal word.
REQ-038 rst_n=0 for one cycle after 2 beats of a word -> no output, next 4 beats produce exactly one word from those beats only.
REQ-039 With EEG_RX_STAT_EN, 65537 single-beat lst frames -> rx_frm_cnt=0x0001; without it rx_frm_cnt=0 throughout.
